fileira_blocos: RTL and testbench

//  Parametrised row of N_BLOCKS breakable blocks for Breakout. Tracks which blocks are alive.

---
 rtl/blocos_pkg.sv | 25 ++
 rtl/fileira_blocos_if.sv | 37 +++
 rtl/fileira_blocos_pulso_timer.sv | 36 +++
 rtl/fileira_blocos.sv | 149 ++++++++++++++
 tb/tb_fileira_blocos.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/blocos_pkg.sv
// Shared definitions for the Breakout block row.
//  - state_t      : game FSM encoding (IDLE, PLAY, GUARD, OVER)
//  - SCREEN_W/H   : VGA playfield size in pixels
//  - BALL_RADIUS  : default ball radius used to widen the collision window
//  - sat_add10    : 10-bit add that clamps at 1023 instead of wrapping
package blocos_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    GUARD = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned BALL_RADIUS = 8;

  function automatic logic [9:0] sat_add10(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[10] ? 10'h3FF : s[9:0];
  endfunction

endpackage

// File: rtl/fileira_blocos_if.sv
// Signal bundle between the block row and the rest of the game.
//  master : game side (drives start and ball position, reads row state)
//  slave  : block row (reads start/ball, drives alive, geometry, hit, endgame)
//  start     1        play enable / rearm
//  x_ball    10       ball centre x
//  y_ball    10       ball centre y
//  alive     N_BLOCKS bit i = block i present
//  x_bloco   10*N     flattened block centres x
//  y_fileira 10       row centre y
//  hit       1        one-cycle pulse per destroyed block
//  hit_idx   4        index of last destroyed block
//  endgame   1        game over
//  win       1        game over with all blocks destroyed
interface fileira_blocos_if #(parameter int unsigned N_BLOCKS = 8);

  logic                    start;
  logic [9:0]              x_ball;
  logic [9:0]              y_ball;
  logic [N_BLOCKS-1:0]     alive;
  logic [10*N_BLOCKS-1:0]  x_bloco;
  logic [9:0]              y_fileira;
  logic                    hit;
  logic [3:0]              hit_idx;
  logic                    endgame;
  logic                    win;

  modport master (
    output start, x_ball, y_ball,
    input  alive, x_bloco, y_fileira, hit, hit_idx, endgame, win
  );

  modport slave (
    input  start, x_ball, y_ball,
    output alive, x_bloco, y_fileira, hit, hit_idx, endgame, win
  );

endinterface

// File: rtl/fileira_blocos_pulso_timer.sv
// Free-running move timer: emits a one-cycle pulse every PERIOD enabled cycles.
//  clock  in  system clock
//  reset  in  asynchronous active-low reset
//  clear  in  synchronous clear; holds the count at zero and masks the pulse
//  en     in  count enable; while low the count and pulse are frozen
//  pulse  out high for the last cycle of each period
module pulso_timer #(
  parameter int unsigned PERIOD = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic pulse
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // in the design samples the values that existed before the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign pulse = en && !clear && (cnt == LAST);

endmodule

// File: rtl/fileira_blocos.sv
// Row of N_BLOCKS breakable Breakout blocks.
// Tracks live blocks, clears the lowest-index block the ball overlaps,
// lowers the row on every move pulse and flags win/loss.
//  clock  in  system clock, rising edge
//  reset  in  asynchronous active-low reset
//  bus    slave side of fileira_blocos_if (start, ball in; row state out)
module fileira_blocos
  import blocos_pkg::*;
#(
  parameter int unsigned N_BLOCKS    = 8,
  parameter int unsigned W_BLOCK     = 32,
  parameter int unsigned H_BLOCK     = 6,
  parameter int unsigned BALL_R      = BALL_RADIUS,
  parameter int unsigned X_ORIGIN    = 0,
  parameter int unsigned Y_START     = 6,
  parameter int unsigned STEP_Y      = 6,
  parameter int unsigned Y_LIMIT     = 440,
  parameter int unsigned MOVE_PERIOD = 25000000
) (
  input logic             clock,
  input logic             reset,
  fileira_blocos_if.slave bus
);

  localparam logic [10:0] X_WIN = 11'(W_BLOCK + BALL_R);
  localparam logic [10:0] Y_WIN = 11'(H_BLOCK + BALL_R);

  state_t              state_q, state_n;
  logic [N_BLOCKS-1:0] alive_q, alive_n;
  logic [N_BLOCKS-1:0] overlap, cand;
  logic [9:0]          y_q, y_n;
  logic                hit_q, hit_n;
  logic [3:0]          idx_q, idx_n, sel;
  logic                win_q, win_n;
  logic                move, timer_clear, y_in, at_limit;
  logic [10:0]         xb, yb, yf;

  pulso_timer #(.PERIOD(MOVE_PERIOD)) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear),
    .en    (bus.start),
    .pulse (move)
  );

  // Collision windows are widened by the ball radius and compared in 11 bits
  // with additions only, so nothing underflows near the screen edges.
  assign xb = {1'b0, bus.x_ball};
  assign yb = {1'b0, bus.y_ball};
  assign yf = {1'b0, y_q};
  assign y_in = (yb + Y_WIN >= yf) && (yb <= yf + Y_WIN);
  assign at_limit = (yf + 11'(H_BLOCK)) >= 11'(Y_LIMIT);

  for (genvar i = 0; i < N_BLOCKS; i++) begin : g_block
    localparam logic [10:0] XC = 11'(X_ORIGIN + W_BLOCK + 2 * W_BLOCK * i);
    assign bus.x_bloco[10*i +: 10] = XC[9:0];
    assign overlap[i] = (xb + X_WIN >= XC) && (xb <= XC + X_WIN) && y_in;
  end

  assign cand = alive_q & overlap;

  // Fixed priority: lowest index wins when the ball straddles two blocks.
  always_comb begin
    sel = '0;
    for (int i = N_BLOCKS - 1; i >= 0; i--) begin
      if (cand[i]) sel = 4'(i);
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n     = state_q;
    alive_n     = alive_q;
    y_n         = y_q;
    hit_n       = 1'b0;
    idx_n       = idx_q;
    win_n       = win_q;
    timer_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        alive_n     = '1;
        y_n         = 10'(Y_START);
        win_n       = 1'b0;
        if (bus.start) state_n = PLAY;
      end
      PLAY, GUARD: begin
        // start low freezes the row in place; the timer is frozen too.
        if (bus.start) begin
          // End checks look at the registered results of the previous update,
          // so endgame rises one cycle after the hit or move that caused it.
          if (alive_q == '0) begin
            state_n = OVER;
            win_n   = 1'b1;
          end else if (at_limit) begin
            state_n = OVER;
            win_n   = 1'b0;
          end else begin
            if (move) y_n = sat_add10(y_q, 10'(STEP_Y));
            if (state_q == PLAY && cand != '0) begin
              alive_n = alive_q & ~(N_BLOCKS'(1) << sel);
              hit_n   = 1'b1;
              idx_n   = sel;
              state_n = GUARD;
            end else if (state_q == GUARD && cand == '0) begin
              state_n = PLAY;
            end
          end
        end
      end
      OVER: begin
        timer_clear = 1'b1;
        if (!bus.start) begin
          state_n = IDLE;
          alive_n = '1;
          y_n     = 10'(Y_START);
          win_n   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      alive_q <= '1;
      y_q     <= 10'(Y_START);
      hit_q   <= 1'b0;
      idx_q   <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      alive_q <= alive_n;
      y_q     <= y_n;
      hit_q   <= hit_n;
      idx_q   <= idx_n;
      win_q   <= win_n;
    end
  end

  assign bus.alive     = alive_q;
  assign bus.y_fileira = y_q;
  assign bus.hit       = hit_q;
  assign bus.hit_idx   = idx_q;
  assign bus.endgame   = (state_q == OVER);
  assign bus.win       = win_q;

endmodule

// File: tb/tb_fileira_blocos.sv
// Directed bench for fileira_blocos.
//  dut_a : 8 blocks, very slow move timer (hit/guard/priority/win tests)
//  dut_b : 8 blocks, move every 4 cycles (descent and loss)
//  dut_c : 1 block,  move every 4 cycles (last hit coincident with limit)
module tb_fileira_blocos;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  fileira_blocos_if #(.N_BLOCKS(8)) bus_a ();
  fileira_blocos_if #(.N_BLOCKS(8)) bus_b ();
  fileira_blocos_if #(.N_BLOCKS(1)) bus_c ();

  fileira_blocos #(.N_BLOCKS(8), .MOVE_PERIOD(100000)) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a)
  );
  fileira_blocos #(.N_BLOCKS(8), .MOVE_PERIOD(4)) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b)
  );
  fileira_blocos #(.N_BLOCKS(1), .MOVE_PERIOD(4)) dut_c (
    .clock (clock), .reset (reset), .bus (bus_c)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    int ks [5];
    logic [7:0] exp_alive [5];
    ks        = '{0, 1, 5, 6, 7};
    exp_alive = '{8'hE2, 8'hE0, 8'hC0, 8'h80, 8'h00};

    bus_a.start = 1'b0; bus_a.x_ball = 10'd1000; bus_a.y_ball = 10'd1000;
    bus_b.start = 1'b0; bus_b.x_ball = 10'd1000; bus_b.y_ball = 10'd1000;
    bus_c.start = 1'b0; bus_c.x_ball = 10'd1000; bus_c.y_ball = 10'd1000;

    // Reset values and constant geometry
    #12;
    check("rst_alive", bus_a.alive, 8'hFF);
    check("rst_y", bus_a.y_fileira, 10'd6);
    check("rst_hit", bus_a.hit, 1'b0);
    check("rst_idx", bus_a.hit_idx, 4'd0);
    check("rst_endgame", bus_a.endgame, 1'b0);
    check("rst_win", bus_a.win, 1'b0);
    check("xb0", bus_a.x_bloco[9:0], 10'd32);
    check("xb2", bus_a.x_bloco[29:20], 10'd160);
    check("xb7", bus_a.x_bloco[79:70], 10'd480);

    // 1) reset asserted mid-PLAY, while a hit pulse is high
    tick();
    reset = 1'b1;
    bus_a.start = 1'b1;
    tick();
    bus_a.x_ball = 10'd32; bus_a.y_ball = 10'd6;
    tick();
    check("t1_hit_before", bus_a.hit, 1'b1);
    check("t1_alive_before", bus_a.alive, 8'hFE);
    reset = 1'b0;
    #1;
    check("t1_alive", bus_a.alive, 8'hFF);
    check("t1_y", bus_a.y_fileira, 10'd6);
    check("t1_endgame", bus_a.endgame, 1'b0);
    check("t1_hit", bus_a.hit, 1'b0);
    tick();
    reset = 1'b1;
    bus_a.start = 1'b0;
    bus_a.x_ball = 10'd1000; bus_a.y_ball = 10'd1000;
    tick();

    // 2) hit on block 2, then no second hit while the ball stays inside
    bus_a.start = 1'b1;
    tick();
    bus_a.x_ball = 10'd160; bus_a.y_ball = 10'd6;
    tick();
    check("t2_hit", bus_a.hit, 1'b1);
    check("t2_idx", bus_a.hit_idx, 4'd2);
    check("t2_alive", bus_a.alive, 8'hFB);
    tick();
    check("t2_hit_pulse_end", bus_a.hit, 1'b0);
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus_a.hit) hits++;
    end
    check("t2_no_second_hit", hits, 0);
    check("t2_alive_hold", bus_a.alive, 8'hFB);
    check("t2_idx_hold", bus_a.hit_idx, 4'd2);
    bus_a.x_ball = 10'd1000; bus_a.y_ball = 10'd1000;
    tick();

    // 3) ball straddling blocks 3 and 4: lower index first
    bus_a.x_ball = 10'd256; bus_a.y_ball = 10'd6;
    tick();
    check("t3_hit_a", bus_a.hit, 1'b1);
    check("t3_idx_a", bus_a.hit_idx, 4'd3);
    check("t3_alive_a", bus_a.alive, 8'hF3);
    tick();
    check("t3_guard_alive", bus_a.alive, 8'hF3);
    bus_a.x_ball = 10'd1000; bus_a.y_ball = 10'd1000;
    tick();
    bus_a.x_ball = 10'd256; bus_a.y_ball = 10'd6;
    tick();
    check("t3_hit_b", bus_a.hit, 1'b1);
    check("t3_idx_b", bus_a.hit_idx, 4'd4);
    check("t3_alive_b", bus_a.alive, 8'hE3);
    bus_a.x_ball = 10'd1000; bus_a.y_ball = 10'd1000;
    tick();

    // 5) destroy the remaining blocks; win one cycle after the last hit
    for (int j = 0; j < 5; j++) begin
      bus_a.x_ball = 10'(32 + 64 * ks[j]); bus_a.y_ball = 10'd6;
      tick();
      check("t5_hit", bus_a.hit, 1'b1);
      check("t5_idx", bus_a.hit_idx, 4'(ks[j]));
      check("t5_alive", bus_a.alive, exp_alive[j]);
      check("t5_endgame_early", bus_a.endgame, 1'b0);
      bus_a.x_ball = 10'd1000; bus_a.y_ball = 10'd1000;
      tick();
    end
    check("t5_endgame", bus_a.endgame, 1'b1);
    check("t5_win", bus_a.win, 1'b1);
    check("t5_y", bus_a.y_fileira, 10'd6);
    repeat (3) tick();
    check("t5_over_hold", bus_a.endgame, 1'b1);
    check("t5_over_alive", bus_a.alive, 8'h00);
    bus_a.start = 1'b0;
    tick();
    check("t5_rearm_endgame", bus_a.endgame, 1'b0);
    check("t5_rearm_win", bus_a.win, 1'b0);
    check("t5_rearm_alive", bus_a.alive, 8'hFF);

    // 4) descent every 4 cycles until the row reaches the loss limit
    bus_b.start = 1'b1;
    tick();
    repeat (3) tick();
    check("t4_y_first_wait", bus_b.y_fileira, 10'd6);
    tick();
    check("t4_y_first_move", bus_b.y_fileira, 10'd12);
    for (int k = 2; k <= 72; k++) begin
      repeat (4) tick();
      check("t4_y_step", bus_b.y_fileira, 10'(6 + 6 * k));
      check("t4_not_over", bus_b.endgame, 1'b0);
    end
    tick();
    check("t4_endgame", bus_b.endgame, 1'b1);
    check("t4_win", bus_b.win, 1'b0);
    repeat (8) tick();
    check("t4_y_frozen", bus_b.y_fileira, 10'd438);
    check("t4_alive", bus_b.alive, 8'hFF);

    // 6) last hit on the same edge as the limit-reaching move: win
    bus_c.start = 1'b1;
    tick();
    repeat (284) tick();
    check("t6_y_pre", bus_c.y_fileira, 10'd432);
    check("t6_alive_pre", bus_c.alive, 1'b1);
    repeat (3) tick();
    bus_c.x_ball = 10'd32; bus_c.y_ball = 10'd432;
    tick();
    check("t6_hit", bus_c.hit, 1'b1);
    check("t6_alive", bus_c.alive, 1'b0);
    check("t6_y", bus_c.y_fileira, 10'd438);
    check("t6_endgame_early", bus_c.endgame, 1'b0);
    tick();
    check("t6_endgame", bus_c.endgame, 1'b1);
    check("t6_win", bus_c.win, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
